// File: rtl/cnn_pkg.sv
// Shared definitions for the dense classifier stage.
//   state_t       : sequencing states of dense_layer (IDLE, MAC, STORE, DONE)
//   acc_width()   : accumulator width that cannot wrap over a full dot product
//   sat_to_width(): signed clamp of a wide value to a WIDTH_BIT range
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One spare bit above the worst-case sum of SIZEIN^2 full-scale products.
    localparam int ACC_GUARD_BITS = 1;

    function automatic int acc_width(input int width_bit, input int sizein);
        return 2 * width_bit + $clog2(sizein * sizein) + ACC_GUARD_BITS;
    endfunction

    // Clamp to [-2^(width_bit-1), 2^(width_bit-1)-1]; caller truncates the result.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                        input int width_bit);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width_bit - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width_bit - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/dense_layer_if.sv
// Bus between the pooling/top level and dense_layer.
//   start         : one-cycle run request (master -> slave)
//   maxPoolingOut : pooled map [SIZEIN][SIZEIN], held stable while busy
//   weights       : per-neuron weight rows, flattened k = i*SIZEIN+j
//   bias          : per-neuron bias
//   fcOut         : saturated neuron results (slave -> master)
//   classIdx      : index of the largest fcOut, lowest index wins ties
//   busy / done   : busy in MAC/STORE, done held in DONE until next start
//   state         : FSM state, exposed for observation
// Handshake: start is a single-cycle pulse honoured only while busy is low;
// done stays high until a new start is accepted or reset is applied.
interface dense_layer_if #(
    parameter int SIZEIN    = 253,
    parameter int NOUT      = 10,
    parameter int WIDTH_BIT = 16
);
    logic                        start;
    logic signed [WIDTH_BIT-1:0] maxPoolingOut [SIZEIN][SIZEIN];
    logic signed [WIDTH_BIT-1:0] weights [NOUT][SIZEIN*SIZEIN];
    logic signed [WIDTH_BIT-1:0] bias [NOUT];
    logic signed [WIDTH_BIT-1:0] fcOut [NOUT];
    logic [$clog2(NOUT)-1:0]     classIdx;
    logic                        busy;
    logic                        done;
    cnn_pkg::state_t             state;

    modport master (
        output start, maxPoolingOut, weights, bias,
        input  fcOut, classIdx, busy, done, state
    );

    modport slave (
        input  start, maxPoolingOut, weights, bias,
        output fcOut, classIdx, busy, done, state
    );
endinterface

// File: rtl/dense_layer_mac_unit.sv
// Registered signed multiply-accumulate.
//   clock, reset : clock and asynchronous active-high reset
//   clear        : synchronous clear of the accumulator (wins over en)
//   en           : add a*b into the accumulator this cycle
//   a, b         : signed WIDTH_BIT operands
//   acc          : signed ACC_W running sum
module mac_unit #(
    parameter int WIDTH_BIT = 16,
    parameter int ACC_W     = 49
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        en,
    input  logic signed [WIDTH_BIT-1:0] a,
    input  logic signed [WIDTH_BIT-1:0] b,
    output logic signed [ACC_W-1:0]     acc
);
    logic signed [2*WIDTH_BIT-1:0] product;

    assign product = a * b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(product);
        end
    end
endmodule

// File: rtl/dense_layer.sv
// Fully connected classifier stage behind the max-pooling block.
// Flattens the pooled map row-major and evaluates NOUT dot products with a
// single time-multiplexed MAC (SIZEIN^2 MAC cycles + 1 STORE cycle per
// neuron), then presents saturated outputs and the argmax class index.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset, clears all state and outputs
//   bus   : dense_layer_if.slave (start, map, weights, bias, fcOut,
//           classIdx, busy, done, state)
// Build option: DENSE_RELU_EN defined applies max(0, x) to each activation
// before it enters the MAC; undefined passes activations unchanged.
module dense_layer
    import cnn_pkg::*;
#(
    parameter int SIZEIN    = 253,
    parameter int NOUT      = 10,
    parameter int WIDTH_BIT = 16,
    parameter int FRAC_BITS = 8
) (
    input logic          clock,
    input logic          reset,
    dense_layer_if.slave bus
);
    localparam int N2    = SIZEIN * SIZEIN;
    localparam int ACC_W = acc_width(WIDTH_BIT, SIZEIN);
    localparam int SUM_W = ACC_W + 1;
    localparam int K_W   = (N2 > 1) ? $clog2(N2) : 1;
    localparam int O_W   = $clog2(NOUT);

    state_t                      state;
    logic [K_W-1:0]              k;
    logic [O_W-1:0]              o;
    logic                        busy;
    logic                        done;
    logic [O_W-1:0]              class_idx;
    logic signed [WIDTH_BIT-1:0] max_val;
    logic signed [WIDTH_BIT-1:0] fc_out [NOUT];

    // Row-major flattening of the pooled map (activation stage included).
    logic signed [WIDTH_BIT-1:0] act_flat [N2];

    for (genvar gi = 0; gi < SIZEIN; gi++) begin : g_row
        for (genvar gj = 0; gj < SIZEIN; gj++) begin : g_col
`ifdef DENSE_RELU_EN
            assign act_flat[gi*SIZEIN+gj] = bus.maxPoolingOut[gi][gj][WIDTH_BIT-1]
                                          ? '0 : bus.maxPoolingOut[gi][gj];
`else
            assign act_flat[gi*SIZEIN+gj] = bus.maxPoolingOut[gi][gj];
`endif
        end
    end

    // MAC control decoded from the state; a fresh run and each STORE clear acc.
    logic                        start_ok;
    logic                        mac_clear;
    logic                        mac_en;
    logic signed [ACC_W-1:0]     acc;

    assign start_ok  = bus.start && (state == IDLE || state == DONE);
    assign mac_clear = start_ok || (state == STORE);
    assign mac_en    = (state == MAC);

    mac_unit #(
        .WIDTH_BIT (WIDTH_BIT),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clock (clock),
        .reset (reset),
        .clear (mac_clear),
        .en    (mac_en),
        .a     (act_flat[k]),
        .b     (bus.weights[o][k]),
        .acc   (acc)
    );

    // Bias is aligned to the product scale, summed with one extra bit of
    // headroom, then scaled back with an arithmetic (floor) shift.
    logic signed [SUM_W-1:0]     bias_ext;
    logic signed [SUM_W-1:0]     sum;
    logic signed [SUM_W-1:0]     shifted;
    logic signed [WIDTH_BIT-1:0] r_sat;

    assign bias_ext = SUM_W'(bus.bias[o]) <<< FRAC_BITS;
    assign sum      = SUM_W'(acc) + bias_ext;
    assign shifted  = sum >>> FRAC_BITS;
    assign r_sat    = WIDTH_BIT'(sat_to_width(64'(shifted), WIDTH_BIT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            o         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            class_idx <= '0;
            max_val   <= '0;
            for (int n = 0; n < NOUT; n++) begin
                fc_out[n] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state <= MAC;
                        k     <= '0;
                        o     <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                MAC: begin
                    if (k == K_W'(N2 - 1)) begin
                        k     <= '0;
                        state <= STORE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                STORE: begin
                    fc_out[o] <= r_sat;
                    // Strict compare: equal results keep the earlier index.
                    if (o == '0 || r_sat > max_val) begin
                        max_val   <= r_sat;
                        class_idx <= o;
                    end
                    k <= '0;
                    if (o == O_W'(NOUT - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        o     <= o + 1'b1;
                        state <= MAC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fcOut    = fc_out;
    assign bus.classIdx = class_idx;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.state    = state;
endmodule
